// File: rtl/ex_mem_pkg.sv
// Shared constants and types for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned ALUOP_W_DEF = 8;

  localparam logic [7:0]  ALUOP_NOP = 8'h00;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Per-cycle register behaviour, decoded from the stall vector (never stored).
  typedef enum logic [1:0] {
    STG_PASS   = 2'd0,
    STG_BUBBLE = 2'd1,
    STG_HOLD   = 2'd2,
    STG_FLUSH  = 2'd3
  } stg_mode_e;

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/bubble handling and madd/msub feedback.
// Optional flush input enabled by defining EX_MEM_FLUSH_EN.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned ALUOP_W = ALUOP_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
`ifdef EX_MEM_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [ADDR_W-1:0]     ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [ADDR_W-1:0]     mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  localparam int unsigned HILO_W = 2 * DATA_W;
  localparam logic [DATA_W-1:0]  ZW     = DATA_W'(ZERO_WORD);
  localparam logic [HILO_W-1:0]  ZW2    = HILO_W'(ZERO_WORD);
  localparam logic [ALUOP_W-1:0] NOP_OP = ALUOP_W'(ALUOP_NOP);

  logic [ADDR_W-1:0]  wd_q,    wd_d;
  logic               wreg_q,  wreg_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  hi_q,    hi_d;
  logic [DATA_W-1:0]  lo_q,    lo_d;
  logic               whilo_q, whilo_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [DATA_W-1:0]  maddr_q, maddr_d;
  logic [DATA_W-1:0]  reg2_q,  reg2_d;
  logic [HILO_W-1:0]  hilo_q,  hilo_d;
  logic [1:0]         cnt_q,   cnt_d;

  stg_mode_e mode_c;

  // Only the EX (3) and MEM (4) stall bits matter here.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Stall decode; flush, when present, overrides every stall state.
  always_comb begin
    mode_c = STG_PASS;
    if (stall[3]) begin
      mode_c = stall[4] ? STG_HOLD : STG_BUBBLE;
    end
`ifdef EX_MEM_FLUSH_EN
    if (flush) begin
      mode_c = STG_FLUSH;
    end
`endif
  end

  // Next-state selection for the MEM payload and the multi-cycle feedback.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    aluop_d = aluop_q;
    maddr_d = maddr_q;
    reg2_d  = reg2_q;
    hilo_d  = ZW2;
    cnt_d   = 2'b00;
    case (mode_c)
      STG_PASS: begin
        wd_d    = ex_wd;
        wreg_d  = ex_wreg;
        wdata_d = ex_wdata;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        whilo_d = ex_whilo;
        aluop_d = ex_aluop;
        maddr_d = ex_mem_addr;
        reg2_d  = ex_reg2;
      end
      STG_BUBBLE, STG_FLUSH: begin
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = ZW;
        hi_d    = ZW;
        lo_d    = ZW;
        whilo_d = 1'b0;
        aluop_d = NOP_OP;
        maddr_d = ZW;
        reg2_d  = ZW;
      end
      default: ;
    endcase
    // EX is frozen during these stalls, so its partial madd/msub state is kept alive.
    if (mode_c == STG_BUBBLE || mode_c == STG_HOLD) begin
      hilo_d = hilo_i;
      cnt_d  = cnt_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= ZW;
      hi_q    <= ZW;
      lo_q    <= ZW;
      whilo_q <= 1'b0;
      aluop_q <= NOP_OP;
      maddr_q <= ZW;
      reg2_q  <= ZW;
      hilo_q  <= ZW2;
      cnt_q   <= 2'b00;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      aluop_q <= aluop_d;
      maddr_q <= maddr_d;
      reg2_q  <= reg2_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd       = wd_q;
  assign mem_wreg     = wreg_q;
  assign mem_wdata    = wdata_q;
  assign mem_hi       = hi_q;
  assign mem_lo       = lo_q;
  assign mem_whilo    = whilo_q;
  assign mem_aluop    = aluop_q;
  assign mem_mem_addr = maddr_q;
  assign mem_reg2     = reg2_q;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for the EX/MEM pipeline register.
module tb_ex_mem;

  localparam logic [7:0] LW_OP = 8'he3;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int checks;
  int failures;

  ex_mem dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
`ifdef EX_MEM_FLUSH_EN
    .flush        (flush),
`endif
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_whilo     (ex_whilo),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
    .hilo_i       (hilo_i),
    .cnt_i        (cnt_i),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_whilo    (mem_whilo),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .hilo_o       (hilo_o),
    .cnt_o        (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wd"},    64'(mem_wd),       64'h0);
    check_eq({tag, "_wreg"},  64'(mem_wreg),     64'h0);
    check_eq({tag, "_wdata"}, 64'(mem_wdata),    64'h0);
    check_eq({tag, "_hi"},    64'(mem_hi),       64'h0);
    check_eq({tag, "_lo"},    64'(mem_lo),       64'h0);
    check_eq({tag, "_whilo"}, 64'(mem_whilo),    64'h0);
    check_eq({tag, "_aluop"}, 64'(mem_aluop),    64'h0);
    check_eq({tag, "_addr"},  64'(mem_mem_addr), 64'h0);
    check_eq({tag, "_reg2"},  64'(mem_reg2),     64'h0);
    check_eq({tag, "_hilo"},  hilo_o,            64'h0);
    check_eq({tag, "_cnt"},   64'(cnt_o),        64'h0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; stall = 6'b0; flush = 1'b0;
    ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'h0; ex_hi = 32'h0; ex_lo = 32'h0;
    ex_whilo = 1'b0; ex_aluop = 8'h0; ex_mem_addr = 32'h0; ex_reg2 = 32'h0;
    hilo_i = 64'h0; cnt_i = 2'd0;

    // Reset state
    #12;
    check_all_zero("reset");
    rst = 1'b1;

    // Plain pass-through, one-cycle latency; EX feedback cleared
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
    ex_hi = 32'hAAAA_0001; ex_lo = 32'hBBBB_0002; ex_whilo = 1'b1;
    ex_aluop = LW_OP; ex_mem_addr = 32'h0000_0100; ex_reg2 = 32'h0000_0055;
    hilo_i = 64'h1111_2222_3333_4444; cnt_i = 2'd2; stall = 6'b000000;
    step();
    check_eq("pass_wd",    64'(mem_wd),       64'd5);
    check_eq("pass_wreg",  64'(mem_wreg),     64'd1);
    check_eq("pass_wdata", 64'(mem_wdata),    64'h1234_5678);
    check_eq("pass_hi",    64'(mem_hi),       64'hAAAA_0001);
    check_eq("pass_lo",    64'(mem_lo),       64'hBBBB_0002);
    check_eq("pass_whilo", 64'(mem_whilo),    64'd1);
    check_eq("pass_aluop", 64'(mem_aluop),    64'he3);
    check_eq("pass_addr",  64'(mem_mem_addr), 64'h100);
    check_eq("pass_reg2",  64'(mem_reg2),     64'h55);
    check_eq("pass_hilo",  hilo_o,            64'h0);
    check_eq("pass_cnt",   64'(cnt_o),        64'h0);

    // EX stalled, MEM running: bubble plus madd/msub state preserved
    stall = 6'b001000; ex_wdata = 32'h0000_CAFE;
    hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    step();
    check_all_zero_except_feedback();
    check_eq("bubble_hilo", hilo_o,      64'h0000_0001_0000_0002);
    check_eq("bubble_cnt",  64'(cnt_o),  64'd1);

    // Release stall: feedback clears
    stall = 6'b000000; ex_wdata = 32'hDEAD_BEEF; ex_wreg = 1'b1;
    step();
    check_eq("rel_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check_eq("rel_hilo",  hilo_o,         64'h0);
    check_eq("rel_cnt",   64'(cnt_o),     64'h0);

    // EX and MEM stalled: hold for several cycles
    stall = 6'b011000; ex_wdata = 32'h1111_1111; ex_wreg = 1'b0;
    hilo_i = 64'h0000_0000_0000_0003; cnt_i = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      check_eq("hold_wreg",  64'(mem_wreg),  64'd1);
      check_eq("hold_cnt",   64'(cnt_o),     64'd3);
    end

    // Other stall bits are ignored
    stall = 6'b100111; ex_wdata = 32'h0000_2222;
    step();
    check_eq("ign_a_wdata", 64'(mem_wdata), 64'h2222);
    check_eq("ign_a_cnt",   64'(cnt_o),     64'h0);
    stall = 6'b110111; ex_wdata = 32'h0000_3333;
    step();
    check_eq("ign_b_wdata", 64'(mem_wdata), 64'h3333);

    // Asynchronous reset between edges
    stall = 6'b000000; ex_wdata = 32'hFFFF_FFFF;
    step();
    check_eq("pre_rst_wdata", 64'(mem_wdata), 64'hFFFF_FFFF);
    #2 rst = 1'b0;
    #1;
    check_all_zero("async_rst");

    // Release mid-stall: HOLD keeps reset values, then a bubble stall captures feedback
    stall = 6'b011000;
    @(negedge clk);
    rst = 1'b1;
    step();
    check_eq("rel_hold_wdata", 64'(mem_wdata), 64'h0);
    check_eq("rel_hold_cnt",   64'(cnt_o),     64'd3);
    stall = 6'b001000; hilo_i = 64'h0000_0005_0000_0006; cnt_i = 2'd2;
    step();
    check_eq("rel_bub_hilo", hilo_o,        64'h0000_0005_0000_0006);
    check_eq("rel_bub_wreg", 64'(mem_wreg), 64'd0);

`ifdef EX_MEM_FLUSH_EN
    // Flush overrides a full hold
    stall = 6'b000000; ex_wreg = 1'b1; ex_wdata = 32'h0000_7777;
    step();
    check_eq("pre_flush_wreg", 64'(mem_wreg), 64'd1);
    flush = 1'b1; stall = 6'b011000; cnt_i = 2'd1;
    step();
    check_eq("flush_wreg",  64'(mem_wreg),  64'd0);
    check_eq("flush_wdata", 64'(mem_wdata), 64'd0);
    check_eq("flush_cnt",   64'(cnt_o),     64'd0);
    flush = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check_all_zero_except_feedback();
    check_eq("bubble_wd",    64'(mem_wd),       64'h0);
    check_eq("bubble_wreg",  64'(mem_wreg),     64'h0);
    check_eq("bubble_wdata", 64'(mem_wdata),    64'h0);
    check_eq("bubble_hi",    64'(mem_hi),       64'h0);
    check_eq("bubble_whilo", 64'(mem_whilo),    64'h0);
    check_eq("bubble_aluop", 64'(mem_aluop),    64'h0);
    check_eq("bubble_addr",  64'(mem_mem_addr), 64'h0);
    check_eq("bubble_reg2",  64'(mem_reg2),     64'h0);
  endtask

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, general-register and memory-address width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter ALUOP_W, default 8, ALU sub-operation code width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous and active-low.
REQ-006 SHALL have port stall, input, 6, pipeline stall vector; bit 3 is the EX stage, bit 4 is the MEM stage.
REQ-007 SHALL have ports ex_wd/ex_wreg/ex_wdata, input, ADDR_W/1/DATA_W, EX destination address, write enable and result.
REQ-008 SHALL have ports ex_hi/ex_lo/ex_whilo, input, DATA_W/DATA_W/1, EX HI/LO values and HI/LO write enable.
REQ-009 SHALL have ports ex_aluop/ex_mem_addr/ex_reg2, input, ALUOP_W/DATA_W/DATA_W, load/store sub-op, effective address and store data (or lwl/lwr merge value).
REQ-010 SHALL have ports hilo_i/cnt_i, input, 2*DATA_W/2, EX multi-cycle (madd/msub) partial product and cycle count.
REQ-011 SHALL have ports mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2, output, widths as the matching ex_* inputs, registered copies to the MEM stage.
REQ-012 SHALL have ports hilo_o/cnt_o, output, 2*DATA_W/2, registered partial product and count fed back to EX.

Function
REQ-013 SHALL, when stall[3]=0, load every mem_* output from its ex_* input on the clock edge (one-cycle latency).
REQ-014 SHALL, when stall[3]=1 and stall[4]=0, load a bubble: mem_wd=0, mem_wreg=0, mem_wdata=0, mem_hi=0, mem_lo=0, mem_whilo=0, mem_aluop=NOP (0), mem_mem_addr=0, mem_reg2=0.
REQ-015 SHALL, when stall[3]=1 and stall[4]=1, hold all mem_* outputs unchanged.
REQ-016 SHALL, when stall[3]=1, load hilo_o from hilo_i and cnt_o from cnt_i (preserve partial madd/msub state across the stall).
REQ-017 SHALL, when stall[3]=0, load hilo_o=0 and cnt_o=0.
REQ-018 SHALL treat the register as a three-state controller per cycle: PASS (stall[3]=0), BUBBLE (stall[3]=1, stall[4]=0), HOLD (stall[3]=1, stall[4]=1); state is derived each cycle, not stored.
REQ-019 SHALL never pass ex_* values into mem_* while stall[3]=1, even if stall[4]=0.
REQ-020 SHALL ignore stall bits other than 3 and 4.
REQ-021 SHALL produce no combinational path from any input to any output.

Reset
REQ-022 SHALL, while rst=0, asynchronously drive all mem_* outputs, hilo_o and cnt_o to 0, mem_aluop to NOP (0).
REQ-023 SHALL, on rst release mid-stall, apply REQ-013..REQ-017 from the first rising clk edge after release.

Configuration
REQ-024 SHALL, with macro EX_MEM_FLUSH_EN defined, add input flush (1 bit); flush=1 on a clock edge SHALL load the REQ-014 bubble and clear hilo_o/cnt_o, overriding all stall states.
REQ-025 SHALL, without EX_MEM_FLUSH_EN, have no flush port, with behaviour exactly as REQ-013..REQ-017.

Structure
REQ-026 SHALL take DATA_W, ADDR_W, ALUOP_W defaults, the NOP aluop code and the zero-word constant from the shared defines package.
REQ-027 SHALL be a single module with no sub-modules; stall decode is inline.

Verification
REQ-028 SHALL check: ex_wd=5, ex_wreg=1, ex_wdata=0x12345678, stall=0 -> next edge mem_wd=5, mem_wreg=1, mem_wdata=0x12345678.
REQ-029 SHALL check: stall=6'b001000 with ex_wreg=1, ex_aluop=LW -> next edge mem_wreg=0, mem_aluop=0, mem_mem_addr=0.
REQ-030 SHALL check: stall=6'b011000 after mem_wdata=0xDEADBEEF -> mem_wdata stays 0xDEADBEEF for every stalled cycle.
REQ-031 SHALL check: stall[3]=1, hilo_i=0x0000000100000002, cnt_i=1 -> hilo_o=0x0000000100000002, cnt_o=1; then stall=0 -> hilo_o=0, cnt_o=0.
REQ-032 SHALL check: rst driven 0 between clock edges while mem_wdata=0xFFFFFFFF -> all outputs 0 immediately, without a clock edge.
REQ-033 SHALL check (EX_MEM_FLUSH_EN): flush=1 with stall=6'b011000 and mem_wreg=1 -> next edge mem_wreg=0, cnt_o=0.
